// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OPA, OPB, FUN, ALU_WAIT, TX_B0, TX_B1
  } state_t;

  typedef enum logic [2:0] {
    TXS_IDLE, TXS_LO, TXS_RISE, TXS_FALL, TXS_HI
  } tx_state_t;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Response sender: one or two bytes to the UART transmitter, pacing the
// second byte on a full TX_BUSY rise/fall after the first strobe.
module uart_cmd_tx_seq
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_two,
  input  logic [DATA_W-1:0] i_lo,
  input  logic [DATA_W-1:0] i_hi,
  input  logic              i_tx_busy,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_vld,
  output logic              o_done
);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_vld;
  logic              r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= TXS_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tx_vld <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        TXS_IDLE: begin
          if (i_start) begin
            r_lo    <= i_lo;
            r_hi    <= i_hi;
            // single-byte responses skip the busy handshake entirely
            r_state <= i_two ? TXS_LO : TXS_HI;
          end
        end
        TXS_LO: begin
          if (!i_tx_busy) begin
            r_tx_data <= r_lo;
            r_tx_vld  <= 1'b1;
            r_state   <= TXS_RISE;
          end
        end
        TXS_RISE: if (i_tx_busy)  r_state <= TXS_FALL;
        TXS_FALL: if (!i_tx_busy) r_state <= TXS_HI;
        TXS_HI: begin
          r_tx_data <= r_hi;
          r_tx_vld  <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= TXS_IDLE;
        end
        default: r_state <= TXS_IDLE;
      endcase
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_vld  = r_tx_vld;
  assign o_done    = r_done;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command frame decoder driving register-file and ALU strobes, with
// an inter-byte timeout that discards stale partial frames.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   RX_P_DATA,
  input  logic                RX_D_VLD,
  input  logic [DATA_W-1:0]   RF_RD_DATA,
  input  logic                RF_RD_VLD,
  input  logic [2*DATA_W-1:0] ALU_OUT,
  input  logic                ALU_OUT_VLD,
  input  logic                TX_BUSY,
  output logic [ADDR_W-1:0]   RF_ADDR,
  output logic                RF_WR_EN,
  output logic                RF_RD_EN,
  output logic [DATA_W-1:0]   RF_WR_DATA,
  output logic                ALU_EN,
  output logic [3:0]          ALU_FUN,
  output logic                ALU_CLK_EN,
  output logic [DATA_W-1:0]   TX_P_DATA,
  output logic                TX_D_VLD,
  output logic                CMD_ERR
);

  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  state_t              r_state;
  logic [TMO_W-1:0]    r_tmo;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic                r_wr_en;
  logic                r_rd_en;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_alu_en;
  logic [3:0]          r_alu_fun;
  logic                r_clk_en;
  logic                r_err;

  logic                w_cnt_state;
  logic                w_tmo;
  logic                w_tx_two;
  logic                w_tx_start;
  logic [DATA_W-1:0]   w_tx_hi;
  logic                w_tx_vld;
  logic                w_tx_done;

  assign w_cnt_state = r_state inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN};
  assign w_tmo       = w_cnt_state && !RX_D_VLD && (r_tmo == TMO_W'(TMO_CYC));
  assign w_tx_two    = (r_state == ALU_WAIT);
  assign w_tx_start  = ((r_state == RD_WAIT) && RF_RD_VLD) || (w_tx_two && ALU_OUT_VLD);
  assign w_tx_hi     = w_tx_two ? ALU_OUT[2*DATA_W-1:DATA_W] : RF_RD_DATA;

  uart_cmd_tx_seq #(.DATA_W(DATA_W)) u_tx_seq (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_start   (w_tx_start),
    .i_two     (w_tx_two),
    .i_lo      (ALU_OUT[DATA_W-1:0]),
    .i_hi      (w_tx_hi),
    .i_tx_busy (TX_BUSY),
    .o_tx_data (TX_P_DATA),
    .o_tx_vld  (w_tx_vld),
    .o_done    (w_tx_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_tmo     <= '0;
      r_rf_addr <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_data <= '0;
      r_alu_en  <= 1'b0;
      r_alu_fun <= '0;
      r_clk_en  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_alu_en <= 1'b0;
      r_err    <= 1'b0;

      if (RX_D_VLD || !w_cnt_state || w_tmo) r_tmo <= '0;
      else                                   r_tmo <= r_tmo + 1'b1;

      if (w_tmo) begin
        r_err    <= 1'b1;
        r_clk_en <= 1'b0;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (RX_D_VLD) begin
              case (RX_P_DATA)
                CMD_WR:      r_state <= WR_ADDR;
                CMD_RD:      r_state <= RD_ADDR;
                CMD_ALU_OP:  begin r_state <= OPA; r_clk_en <= 1'b1; end
                CMD_ALU_NOP: begin r_state <= FUN; r_clk_en <= 1'b1; end
                default:     r_err <= 1'b1;
              endcase
            end
          end
          WR_ADDR: if (RX_D_VLD) begin
            r_rf_addr <= RX_P_DATA[ADDR_W-1:0];
            r_state   <= WR_DATA;
          end
          WR_DATA: if (RX_D_VLD) begin
            r_wr_data <= RX_P_DATA;
            r_wr_en   <= 1'b1;
            r_state   <= IDLE;
          end
          RD_ADDR: if (RX_D_VLD) begin
            r_rf_addr <= RX_P_DATA[ADDR_W-1:0];
            r_rd_en   <= 1'b1;
            r_state   <= RD_WAIT;
          end
          RD_WAIT:  if (RF_RD_VLD) r_state <= TX_B1;
          OPA: if (RX_D_VLD) begin
            r_rf_addr <= ADDR_W'(OPA_ADDR);
            r_wr_data <= RX_P_DATA;
            r_wr_en   <= 1'b1;
            r_state   <= OPB;
          end
          OPB: if (RX_D_VLD) begin
            r_rf_addr <= ADDR_W'(OPB_ADDR);
            r_wr_data <= RX_P_DATA;
            r_wr_en   <= 1'b1;
            r_state   <= FUN;
          end
          FUN: if (RX_D_VLD) begin
            r_alu_fun <= RX_P_DATA[3:0];
            r_alu_en  <= 1'b1;
            r_state   <= ALU_WAIT;
          end
          ALU_WAIT: if (ALU_OUT_VLD) r_state <= TX_B0;
          // TX_B0 -> TX_B1 once the low byte is out; the sender paces the rest
          TX_B0:    if (w_tx_vld)  r_state <= TX_B1;
          TX_B1: if (w_tx_done) begin
            r_clk_en <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign RF_ADDR    = r_rf_addr;
  assign RF_WR_EN   = r_wr_en;
  assign RF_RD_EN   = r_rd_en;
  assign RF_WR_DATA = r_wr_data;
  assign ALU_EN     = r_alu_en;
  assign ALU_FUN    = r_alu_fun;
  assign ALU_CLK_EN = r_clk_en;
  assign TX_D_VLD   = w_tx_vld;
  assign CMD_ERR    = r_err;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer on the UART receive path of the system-clock domain.
- Consumes bytes from the UART receiver (RX_P_DATA / RX_D_VLD) and decodes multi-byte command frames.
- Drives register-file writes and reads plus ALU operations, then returns results as bytes to the UART transmitter.
- Contains an inter-byte timeout that aborts stale partial frames.

Parameters:
- DATA_W, 8, byte width on RX/TX/register-file data.
- ADDR_W, 4, register-file address width.
- TMO_CYC, 1023, CLK cycles allowed between frame bytes before abort (10-bit counter).
- CMD_WR, 8'hAA, opcode for a register write: AA, addr, data.
- CMD_RD, 8'hBB, opcode for a register read: BB, addr.
- CMD_ALU_OP, 8'hCC, opcode for an ALU op with operands: CC, A, B, fun.
- CMD_ALU_NOP, 8'hDD, opcode for an ALU op on stored operands: DD, fun.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  DATA_W  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid.
- RF_RD_DATA  in  DATA_W  register-file read data.
- RF_RD_VLD  in  1  read data valid, 1 cycle after RF_RD_EN.
- ALU_OUT  in  2*DATA_W  ALU result.
- ALU_OUT_VLD  in  1  result valid, 1 cycle after ALU_EN.
- TX_BUSY  in  1  transmitter busy (synchronised).
- RF_ADDR  out  ADDR_W  register-file address.
- RF_WR_EN  out  1  write strobe.
- RF_RD_EN  out  1  read strobe.
- RF_WR_DATA  out  DATA_W  write data.
- ALU_EN  out  1  one-cycle ALU start.
- ALU_FUN  out  4  ALU function (fun byte [3:0]).
- ALU_CLK_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_W  byte to transmit.
- TX_D_VLD  out  1  one-cycle transmit strobe.
- CMD_ERR  out  1  one-cycle pulse on bad opcode or timeout.

Behaviour:
- Reset: every output is 0; state is IDLE; timeout counter is 0.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_B0, TX_B1.
- IDLE, on RX_D_VLD:
  - AA goes to WR_ADDR.
  - BB goes to RD_ADDR.
  - CC goes to OPA and raises ALU_CLK_EN.
  - DD goes to FUN and raises ALU_CLK_EN.
  - Any other byte pulses CMD_ERR and stays in IDLE.
- WR_ADDR: latch RX_P_DATA[ADDR_W-1:0] as the address, then go to WR_DATA.
- WR_DATA, on a byte: drive RF_WR_EN=1 for exactly 1 cycle with the latched address and the byte, then go to IDLE.
- RD_ADDR, on a byte: drive RF_RD_EN=1 for 1 cycle, then go to RD_WAIT.
- RD_WAIT, on RF_RD_VLD: capture the data into the tx buffer and go to TX_B1, a single-byte send.
- OPA, on a byte: write RF address 0, then go to OPB.
- OPB, on a byte: write RF address 1, then go to FUN.
- FUN, on a byte: latch ALU_FUN, pulse ALU_EN for 1 cycle, then go to ALU_WAIT.
- ALU_WAIT, on ALU_OUT_VLD: capture 16 bits and go to TX_B0.
- TX_B0: when TX_BUSY=0, pulse TX_D_VLD with the low byte, then go to TX_B1.
- TX_B1:
  - Wait for TX_BUSY to rise, then fall, after the prior strobe; skip this wait if entering from RD_WAIT.
  - Then pulse TX_D_VLD with the high byte (ALU) or the read byte, then go to IDLE.
  - ALU_CLK_EN drops on entry to IDLE.
- ALU_FUN holds its value until the next FUN byte.
- RF_ADDR holds its last value.
- Timeout:
  - The counter clears on every RX_D_VLD and counts only in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN.
  - When the counter reaches TMO_CYC: pulse CMD_ERR, go to IDLE, and perform no RF or ALU strobe.
- RX_D_VLD in a wait or TX state: the byte is dropped and no error is flagged.
- Only one strobe among RF_WR_EN, RF_RD_EN, ALU_EN and TX_D_VLD is ever high in a given cycle.
- RST mid-frame: on the next edge, return to the reset state; a partial write never completes.
- Latency: a write strobe comes 1 cycle after the data byte's RX_D_VLD. The first TX strobe comes at the earliest 1 cycle after the capture cycle.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum;
  - opcode constants;
  - operand addresses OPA_ADDR=0 and OPB_ADDR=1.
- One sub-module, uart_cmd_tx_seq: TX_BUSY edge tracking and the two-byte send sequencer, with a start/done handshake.

Test Plan:
- Write, then read back:
  - Send AA,05,3C. Expect RF_WR_EN for 1 cycle with addr 5, data 3C.
  - Then send BB,05, with RF returning 3C. Expect a single TX_D_VLD with 3C.
- ALU op with operands:
  - Send CC,12,34,00, with ALU_OUT=0046.
  - Expect writes to addr 0 (12) and addr 1 (34), ALU_FUN=0 and an ALU_EN pulse.
  - Expect TX 46, then 00 only after a TX_BUSY rise and fall.
- Send 7E. Expect a CMD_ERR pulse, no other strobes, state IDLE; a following AA frame works normally.
- Send AA,05 and then idle for 1023 cycles. Expect CMD_ERR at the timeout and no RF_WR_EN. A late data byte is then decoded as an opcode.
- Send DD,02, with ALU_OUT=FFFE. Expect ALU_EN with fun 2, then TX FE, FF; ALU_CLK_EN is 0 after completion.
- Assert RST during OPB of a CC frame. Expect all outputs 0 on the next cycle and no ALU_EN afterwards.
